// File: rtl/calf_nic_ctrl_pkg.sv
// rtl/calf_nic_ctrl_pkg.sv - flit geometry and helpers shared by the CALF NIC controller
package calf_nic_ctrl_pkg;

   localparam int CONTROL_W = 32;
   localparam int VALID_F   = CONTROL_W - 1;
   localparam int NIC_DEPTH = 4;

   typedef logic [CONTROL_W-1:0] flit_t;

   function automatic flit_t set_valid(input flit_t f);
      flit_t v;
      v          = f;
      v[VALID_F] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/calf_nic_ctrl_inj_fifo.sv
// rtl/calf_nic_ctrl_inj_fifo.sv - injection FIFO; head is read straight from registered storage
module calf_nic_ctrl_inj_fifo
   import calf_nic_ctrl_pkg::*;
#(
   parameter int DEPTH = NIC_DEPTH
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  flit_t                  i_data,
   input  logic                   i_push,
   input  logic                   i_pop,
   output flit_t                  o_head,
   output logic                   o_empty,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   flit_t          r_mem [DEPTH];
   logic [AW-1:0]  r_wr_ptr;
   logic [AW-1:0]  r_rd_ptr;
   logic [AW:0]    r_count;
   logic           w_push;
   logic           w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/calf_nic_ctrl.sv
// rtl/calf_nic_ctrl.sv - CALF router port4 injection/ejection controller; optional gap throttling via CALF_NIC_THROTTLE_EN
module calf_nic_ctrl
   import calf_nic_ctrl_pkg::*;
#(
   parameter int DEPTH     = NIC_DEPTH,
   parameter int STARVE_W  = 8,
   parameter int STARVE_TH = 64
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CONTROL_W-1:0] core_flit_i,
   input  logic                 core_valid_i,
   output logic                 core_ready_o,
   output logic [CONTROL_W-1:0] port4_ci_o,
   input  logic                 port4_ack_i,
   input  logic [CONTROL_W-1:0] port4_co_i,
   output logic [CONTROL_W-1:0] ej_flit_o,
   output logic                 ej_valid_o,
   output logic                 starved_o,
   output logic [15:0]          inj_count_o,
   output logic [15:0]          ej_count_o,
   input  logic [7:0]           throttle_gap_i
);

   localparam logic [STARVE_W-1:0] TH_W = STARVE_W'(STARVE_TH);

   flit_t                  w_head;
   logic                   w_empty;
   logic                   w_full;
   logic [$clog2(DEPTH):0] w_unused_count;
   logic                   w_throttled;
   logic                   w_head_vld;
   logic                   w_pop;
   logic [STARVE_W-1:0]    r_starve;
   logic [STARVE_W-1:0]    w_starve_nxt;
   logic                   r_starved;
   logic [15:0]            r_inj_cnt;
   logic [15:0]            r_ej_cnt;
   flit_t                  r_ej_flit;
   logic                   r_ej_valid;

   calf_nic_ctrl_inj_fifo #(.DEPTH(DEPTH)) u_inj_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (set_valid(core_flit_i)),
      .i_push  (core_valid_i),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_unused_count)
   );

`ifdef CALF_NIC_THROTTLE_EN
   logic [7:0] r_gap;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gap <= '0;
      end else if (w_pop) begin
         r_gap <= throttle_gap_i;
      end else if (r_gap != 8'd0) begin
         r_gap <= r_gap - 1'b1;
      end
   end

   assign w_throttled = (r_gap != 8'd0);
`else
   logic w_unused_gap;
   assign w_unused_gap = ^throttle_gap_i;
   assign w_throttled  = 1'b0;
`endif

   // Head visibility depends only on registers, so ack never feeds back into port4_ci_o.
   assign w_head_vld   = ~w_empty & ~w_throttled;
   assign w_pop        = port4_ack_i & w_head_vld;
   assign port4_ci_o   = w_head_vld ? w_head : '0;
   assign core_ready_o = ~w_full;

   always_comb begin
      w_starve_nxt = r_starve;
      if (w_empty || w_pop) begin
         w_starve_nxt = '0;
      end else if (w_head_vld && (r_starve != '1)) begin
         w_starve_nxt = r_starve + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve   <= '0;
         r_starved  <= 1'b0;
         r_inj_cnt  <= '0;
         r_ej_cnt   <= '0;
         r_ej_flit  <= '0;
         r_ej_valid <= 1'b0;
      end else begin
         r_starve   <= w_starve_nxt;
         r_starved  <= (w_starve_nxt >= TH_W);
         r_ej_flit  <= port4_co_i;
         r_ej_valid <= port4_co_i[VALID_F];
         if (w_pop) begin
            r_inj_cnt <= r_inj_cnt + 1'b1;
         end
         if (port4_co_i[VALID_F]) begin
            r_ej_cnt <= r_ej_cnt + 1'b1;
         end
      end
   end

   assign starved_o   = r_starved;
   assign inj_count_o = r_inj_cnt;
   assign ej_count_o  = r_ej_cnt;
   assign ej_flit_o   = r_ej_flit;
   assign ej_valid_o  = r_ej_valid;

endmodule

// File: tb/tb_calf_nic_ctrl.sv
// tb/tb_calf_nic_ctrl.sv - directed self-checking bench for calf_nic_ctrl
module tb_calf_nic_ctrl;
   import calf_nic_ctrl_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [CONTROL_W-1:0] core_flit_i;
   logic                 core_valid_i;
   logic                 core_ready_o;
   logic [CONTROL_W-1:0] port4_ci_o;
   logic                 port4_ack_i;
   logic [CONTROL_W-1:0] port4_co_i;
   logic [CONTROL_W-1:0] ej_flit_o;
   logic                 ej_valid_o;
   logic                 starved_o;
   logic [15:0]          inj_count_o;
   logic [15:0]          ej_count_o;
   logic [7:0]           throttle_gap_i;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   calf_nic_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .core_flit_i    (core_flit_i),
      .core_valid_i   (core_valid_i),
      .core_ready_o   (core_ready_o),
      .port4_ci_o     (port4_ci_o),
      .port4_ack_i    (port4_ack_i),
      .port4_co_i     (port4_co_i),
      .ej_flit_o      (ej_flit_o),
      .ej_valid_o     (ej_valid_o),
      .starved_o      (starved_o),
      .inj_count_o    (inj_count_o),
      .ej_count_o     (ej_count_o),
      .throttle_gap_i (throttle_gap_i)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n          = 1'b0;
      core_flit_i    = '0;
      core_valid_i   = 1'b0;
      port4_ack_i    = 1'b0;
      port4_co_i     = '0;
      throttle_gap_i = 8'd0;
      tick();
      tick();
      chk("rst_ci", port4_ci_o, 32'h0);
      chk("rst_ready", {31'b0, core_ready_o}, 32'h1);
      chk("rst_ejv", {31'b0, ej_valid_o}, 32'h0);
      chk("rst_starved", {31'b0, starved_o}, 32'h0);
      chk("rst_inj", {16'b0, inj_count_o}, 32'h0);
      chk("rst_ej", {16'b0, ej_count_o}, 32'h0);
      rst_n = 1'b1;

      // single flit, ack held high
      core_flit_i  = 32'h0000_0011;
      core_valid_i = 1'b1;
      port4_ack_i  = 1'b1;
      tick();
      core_valid_i = 1'b0;
      chk("t1_ci", port4_ci_o, 32'h8000_0011);
      chk("t1_inj0", {16'b0, inj_count_o}, 32'd0);
      tick();
      chk("t1_ci_empty", port4_ci_o, 32'h0);
      chk("t1_inj1", {16'b0, inj_count_o}, 32'd1);
      port4_ack_i = 1'b0;

      // fill to full, overflow push dropped, drain in order
      for (int i = 0; i < 4; i++) begin
         core_flit_i  = 32'h21 + i;
         core_valid_i = 1'b1;
         tick();
      end
      chk("t2_ready_full", {31'b0, core_ready_o}, 32'h0);
      core_flit_i = 32'h25;
      tick();
      core_valid_i = 1'b0;
      chk("t2_head", port4_ci_o, 32'h8000_0021);
      port4_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("t2_order", port4_ci_o, 32'h8000_0021 + i);
         tick();
      end
      port4_ack_i = 1'b0;
      chk("t2_drained", port4_ci_o, 32'h0);
      chk("t2_inj", {16'b0, inj_count_o}, 32'd5);
      chk("t2_ready", {31'b0, core_ready_o}, 32'h1);

      // starvation threshold
      core_flit_i  = 32'h31;
      core_valid_i = 1'b1;
      tick();
      core_valid_i = 1'b0;
      for (int i = 0; i < 63; i++) tick();
      chk("t3_not_starved", {31'b0, starved_o}, 32'h0);
      tick();
      chk("t3_starved", {31'b0, starved_o}, 32'h1);
      port4_ack_i = 1'b1;
      tick();
      port4_ack_i = 1'b0;
      chk("t3_cleared", {31'b0, starved_o}, 32'h0);
      chk("t3_inj", {16'b0, inj_count_o}, 32'd6);

      // ejection
      for (int i = 0; i < 3; i++) begin
         port4_co_i = 32'h8000_0A01 + i;
         tick();
         chk("t4_ejv", {31'b0, ej_valid_o}, 32'h1);
         chk("t4_ejf", ej_flit_o, 32'h8000_0A01 + i);
      end
      port4_co_i = 32'h0000_0A04;
      tick();
      port4_co_i = '0;
      chk("t4_ejv_low", {31'b0, ej_valid_o}, 32'h0);
      chk("t4_ej_count", {16'b0, ej_count_o}, 32'd3);

      // reset mid-operation
      for (int i = 0; i < 3; i++) begin
         core_flit_i  = 32'h51 + i;
         core_valid_i = 1'b1;
         tick();
      end
      core_valid_i = 1'b0;
      chk("t5_pre_head", port4_ci_o, 32'h8000_0051);
      rst_n       = 1'b0;
      port4_ack_i = 1'b1;
      tick();
      rst_n       = 1'b1;
      port4_ack_i = 1'b0;
      chk("t5_ci", port4_ci_o, 32'h0);
      chk("t5_ready", {31'b0, core_ready_o}, 32'h1);
      chk("t5_inj", {16'b0, inj_count_o}, 32'd0);
      chk("t5_ej", {16'b0, ej_count_o}, 32'd0);
      chk("t5_starved", {31'b0, starved_o}, 32'h0);
      core_flit_i  = 32'h61;
      core_valid_i = 1'b1;
      tick();
      core_valid_i = 1'b0;
      chk("t5_post_push", port4_ci_o, 32'h8000_0061);
      port4_ack_i = 1'b1;
      tick();
      port4_ack_i = 1'b0;
      chk("t5_post_inj", {16'b0, inj_count_o}, 32'd1);

`ifdef CALF_NIC_THROTTLE_EN
      // gap of 2 idle cycles after each injection
      throttle_gap_i = 8'd2;
      for (int i = 0; i < 3; i++) begin
         core_flit_i  = 32'h71 + i;
         core_valid_i = 1'b1;
         tick();
      end
      core_valid_i = 1'b0;
      port4_ack_i  = 1'b1;
      for (int c = 0; c < 7; c++) begin
         if ((c % 3) == 0) chk("t6_inject", port4_ci_o, 32'h8000_0071 + (c / 3));
         else              chk("t6_gap", port4_ci_o, 32'h0);
         tick();
      end
      port4_ack_i = 1'b0;
      chk("t6_inj", {16'b0, inj_count_o}, 32'd4);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
